// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative HI/LO multiply/divide unit for the EX stage. Handles MULT,
//   MULTU, DIV, DIVU (via Start/Op) and MTHI/MTLO (via MthiEn/MtloEn).
//   Hi/Lo feed the EX-stage result mux for MFHI/MFLO; Busy stalls the pipe.
//
//   Ports
//     Clk     in   clock, rising-edge
//     Reset   in   synchronous active-high reset
//     Start   in   begin operation Op on Rs/Rt (accepted only in IDLE)
//     Op      in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     Rs      in   multiplicand / dividend / MTHI-MTLO source
//     Rt      in   multiplier / divisor
//     MthiEn  in   write Rs into Hi when idle and not starting
//     MtloEn  in   write Rs into Lo when idle and not starting
//     Hi      out  product high word / remainder
//     Lo      out  product low word / quotient
//     Busy    out  operation in progress
//     Done    out  one-cycle pulse when Hi/Lo were written by an operation
//
//   Sequence: IDLE -> PREP (1) -> CALC (DATA_WIDTH) -> FIX (1) -> IDLE.
//   IDLE only latches the raw operands; PREP forms the absolute values so
//   the negation adders sit behind a register instead of on the input path.
//   Busy is high during CALC and FIX, and Hi/Lo are written with Done on
//   the FIX->IDLE edge, giving a fixed latency of DATA_WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [DATA_WIDTH-1:0] Rs,
    input  logic [DATA_WIDTH-1:0] Rt,
    input  logic                  MthiEn,
    input  logic                  MtloEn,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo,
    output logic                  Busy,
    output logic                  Done
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic [W-1:0]    a_q;        // raw Rs, then |Rs| (multiplicand)
    logic [W-1:0]    b_q;        // raw Rt, then |Rt| (divisor)
    logic [W-1:0]    rs_raw_q;   // original dividend for divide-by-zero
    logic            sign_a_q;
    logic            sign_b_q;
    logic [W-1:0]    acc_hi_q;   // product high / partial remainder
    logic [W-1:0]    acc_lo_q;   // multiplier-product low / dividend-quotient
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic            busy_q;
    logic            done_q;

    logic [W-1:0]    abs_a_d;
    logic [W-1:0]    abs_b_d;
    logic [W:0]      mul_sum_s;
    logic [W:0]      div_shift_s;
    logic [W:0]      div_diff_s;
    logic [W-1:0]    step_hi_d;
    logic [W-1:0]    step_lo_d;
    logic [2*W-1:0]  prod_s;
    logic [2*W-1:0]  prod_neg_s;
    logic [W-1:0]    fix_hi_d;
    logic [W-1:0]    fix_lo_d;

    // Datapath: operand magnitudes, one shift-add / restoring step, sign fix
    always_comb begin
        abs_a_d     = a_q;
        abs_b_d     = b_q;
        mul_sum_s   = {(W+1){1'b0}};
        div_shift_s = {(W+1){1'b0}};
        div_diff_s  = {(W+1){1'b0}};
        step_hi_d   = acc_hi_q;
        step_lo_d   = acc_lo_q;
        prod_s      = {acc_hi_q, acc_lo_q};
        prod_neg_s  = {(2*W){1'b0}} - prod_s;
        fix_hi_d    = acc_hi_q;
        fix_lo_d    = acc_lo_q;

        // sign flags are only ever set for signed ops
        if (sign_a_q) begin
            abs_a_d = {W{1'b0}} - a_q;
        end else begin
            abs_a_d = a_q;
        end
        if (sign_b_q) begin
            abs_b_d = {W{1'b0}} - b_q;
        end else begin
            abs_b_d = b_q;
        end

        // multiply: add multiplicand if multiplier LSB set, then shift the
        // 2W-bit {hi,lo} pair right; multiplier bits drain out of lo
        mul_sum_s = {1'b0, acc_hi_q} + ({1'b0, a_q} & {(W+1){acc_lo_q[0]}});

        // divide: shift next dividend bit into remainder and trial-subtract;
        // remainder < divisor keeps the difference inside W+1 bits, so its
        // MSB is a clean borrow flag
        div_shift_s = {acc_hi_q, acc_lo_q[W-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q};

        if (op_q[1]) begin
            if (!div_diff_s[W]) begin
                step_hi_d = div_diff_s[W-1:0];
                step_lo_d = {acc_lo_q[W-2:0], 1'b1};
            end else begin
                step_hi_d = div_shift_s[W-1:0];
                step_lo_d = {acc_lo_q[W-2:0], 1'b0};
            end
        end else begin
            step_hi_d = mul_sum_s[W:1];
            step_lo_d = {mul_sum_s[0], acc_lo_q[W-1:1]};
        end

        // final two's-complement correction
        if (!op_q[1]) begin
            if (sign_a_q ^ sign_b_q) begin
                fix_hi_d = prod_neg_s[2*W-1:W];
                fix_lo_d = prod_neg_s[W-1:0];
            end else begin
                fix_hi_d = acc_hi_q;
                fix_lo_d = acc_lo_q;
            end
        end else if (b_q == {W{1'b0}}) begin
            // divide by zero: hand back the untouched dividend, all-ones quotient
            fix_hi_d = rs_raw_q;
            fix_lo_d = {W{1'b1}};
        end else begin
            if (sign_a_q ^ sign_b_q) begin
                fix_lo_d = {W{1'b0}} - acc_lo_q;
            end else begin
                fix_lo_d = acc_lo_q;
            end
            if (sign_a_q) begin
                fix_hi_d = {W{1'b0}} - acc_hi_q;
            end else begin
                fix_hi_d = acc_hi_q;
            end
        end
    end

    // Control FSM and all architectural / working registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            op_q     <= 2'b00;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            rs_raw_q <= {W{1'b0}};
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_hi_q <= {W{1'b0}};
            acc_lo_q <= {W{1'b0}};
            hi_q     <= {W{1'b0}};
            lo_q     <= {W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (Start) begin
                        op_q     <= Op;
                        a_q      <= Rs;
                        b_q      <= Rt;
                        rs_raw_q <= Rs;
                        // Op[0]=0 marks the signed variants
                        sign_a_q <= ~Op[0] & Rs[W-1];
                        sign_b_q <= ~Op[0] & Rt[W-1];
                        state_q  <= S_PREP;
                    end else begin
                        if (MthiEn) begin
                            hi_q <= Rs;
                        end
                        if (MtloEn) begin
                            lo_q <= Rs;
                        end
                    end
                end
                S_PREP: begin
                    a_q      <= abs_a_d;
                    b_q      <= abs_b_d;
                    acc_hi_q <= {W{1'b0}};
                    acc_lo_q <= op_q[1] ? abs_a_d : abs_b_d;
                    cnt_q    <= {CW{1'b0}};
                    busy_q   <= 1'b1;
                    state_q  <= S_CALC;
                end
                S_CALC: begin
                    acc_hi_q <= step_hi_d;
                    acc_lo_q <= step_lo_d;
                    busy_q   <= 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Table of {Op, Rs, Rt, expected Hi, expected Lo} applied back-to-back,
//   followed by hand-written sequences for the multi-cycle corner cases.
//   Expected results go into a scoreboard queue at Start and are popped when
//   Done is seen. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [1:0]    Op;
    logic [W-1:0]  Rs;
    logic [W-1:0]  Rt;
    logic          MthiEn;
    logic          MtloEn;
    logic [W-1:0]  Hi;
    logic [W-1:0]  Lo;
    logic          Busy;
    logic          Done;

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Op     (Op),
        .Rs     (Rs),
        .Rt     (Rt),
        .MthiEn (MthiEn),
        .MtloEn (MtloEn),
        .Hi     (Hi),
        .Lo     (Lo),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    localparam int NVEC = 16;
    vec_t tbl [NVEC];
    exp_t sb [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model built on the simulator's own arithmetic
    task automatic model(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                         output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [63:0] p;
        p  = 64'd0;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            2'b00: begin
                p  = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                p  = {32'd0, rs} * {32'd0, rt};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b10: begin
                if (rt == 32'd0) begin
                    hi = rs;
                    lo = 32'hFFFF_FFFF;
                end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
                    hi = 32'd0;
                    lo = 32'h8000_0000;
                end else begin
                    lo = $signed(rs) / $signed(rt);
                    hi = $signed(rs) % $signed(rt);
                end
            end
            default: begin
                if (rt == 32'd0) begin
                    hi = rs;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    lo = rs / rt;
                    hi = rs % rt;
                end
            end
        endcase
    endtask

    // Start one operation at the current falling edge and run it to Done.
    // Returns on the falling edge where Done is seen, so the caller may start
    // the next operation in the Done cycle. mt raises MthiEn/MtloEn together
    // with Start; inject fires an extra Start(DIVU)+MthiEn mid-operation.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input string name, input bit mt, input bit inject);
        exp_t e;
        exp_t got;
        int   busy_n;
        int   lat;
        bit   seen;
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
        prev_hi = Hi;
        prev_lo = Lo;
        Start  = 1'b1;
        Op     = op;
        Rs     = rs;
        Rt     = rt;
        MthiEn = mt;
        MtloEn = mt;
        e.hi = exp_hi;
        e.lo = exp_lo;
        sb.push_back(e);
        busy_n = 0;
        lat    = 0;
        seen   = 1'b0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge Clk);
            if (i == 1) begin
                Start  = 1'b0;
                MthiEn = 1'b0;
                MtloEn = 1'b0;
                if (mt) begin
                    check({name, " hi kept at start"}, Hi, prev_hi);
                    check({name, " lo kept at start"}, Lo, prev_lo);
                end
            end
            // operand changes after capture must not matter
            Op = 2'($urandom_range(0, 3));
            Rs = $urandom;
            Rt = $urandom;
            if (inject && i == 5) begin
                Start  = 1'b1;
                Op     = 2'b11;
                Rs     = 32'd99;
                Rt     = 32'd3;
                MthiEn = 1'b1;
            end
            if (inject && i == 6) begin
                Start  = 1'b0;
                MthiEn = 1'b0;
                check({name, " hi held while busy"}, Hi, prev_hi);
            end
            if (Busy) busy_n++;
            if (Done) begin
                seen = 1'b1;
                lat  = i - 1;
            end
        end
        check({name, " done seen"}, seen, 1'b1);
        if (sb.size() == 0) begin
            check({name, " scoreboard entry"}, 0, 1);
        end else begin
            got = sb.pop_front();
            if (seen) begin
                check({name, " hi"}, Hi, got.hi);
                check({name, " lo"}, Lo, got.lo);
                check({name, " latency"}, lat, 34);
                check({name, " busy cycles"}, busy_n, 33);
            end
        end
    endtask

    initial begin
        int nd;
        Reset  = 1'b1;
        Start  = 1'b0;
        Op     = 2'b00;
        Rs     = 32'd0;
        Rt     = 32'd0;
        MthiEn = 1'b0;
        MtloEn = 1'b0;

        tbl[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        tbl[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4]  = '{2'b11, 32'd7,         32'd2,        32'd1,         32'd3};
        tbl[5]  = '{2'b11, 32'h10,        32'd0,        32'h10,        32'hFFFF_FFFF};
        tbl[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
        tbl[7]  = '{2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
        tbl[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
        tbl[9]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        tbl[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,        32'h0,         32'hFFFF_FFFF};
        tbl[11] = '{2'b01, 32'd0,         32'h1234_5678, 32'h0,        32'h0};
        for (int i = 12; i < NVEC; i++) begin
            tbl[i].op = 2'(i - 12);
            tbl[i].rs = $urandom;
            tbl[i].rt = (i >= 14) ? 32'($urandom_range(1, 5000)) : $urandom;
            model(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo);
        end

        // reset state
        repeat (3) @(negedge Clk);
        check("reset hi", Hi, 32'd0);
        check("reset lo", Lo, 32'd0);
        check("reset busy", Busy, 1'b0);
        check("reset done", Done, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);

        // MTHI and MTLO together
        Rs = 32'h1234_5678;
        MthiEn = 1'b1;
        MtloEn = 1'b1;
        @(negedge Clk);
        MthiEn = 1'b0;
        MtloEn = 1'b0;
        check("mthi+mtlo hi", Hi, 32'h1234_5678);
        check("mthi+mtlo lo", Lo, 32'h1234_5678);

        // table, each op started in the previous op's Done cycle
        for (int i = 0; i < NVEC; i++) begin
            run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo,
                   $sformatf("vec%0d", i), 1'b0, 1'b0);
        end

        // Done is a single-cycle pulse and Hi/Lo hold afterwards
        @(negedge Clk);
        check("done pulse width", Done, 1'b0);
        check("hi hold", Hi, tbl[NVEC-1].hi);
        check("lo hold", Lo, tbl[NVEC-1].lo);

        // MULT 6*7 with Start(DIVU)+MthiEn injected while busy
        run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, "mult6x7 inject", 1'b0, 1'b1);

        // MTLO in IDLE
        Rs = 32'h0000_ABCD;
        MtloEn = 1'b1;
        @(negedge Clk);
        MtloEn = 1'b0;
        check("mtlo lo", Lo, 32'h0000_ABCD);
        check("mtlo hi untouched", Hi, 32'd0);

        // Start wins over MthiEn/MtloEn in the same cycle
        run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, "start over mt", 1'b1, 1'b0);

        // reset 10 cycles into a DIV
        Start = 1'b1;
        Op    = 2'b10;
        Rs    = 32'hFFFF_FFF9;
        Rt    = 32'd2;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("mid reset hi", Hi, 32'd0);
        check("mid reset lo", Lo, 32'd0);
        check("mid reset busy", Busy, 1'b0);
        check("mid reset done", Done, 1'b0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done || Busy) nd++;
        end
        check("no activity after reset", nd, 0);

        run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, "mult2x3 after reset", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
